regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the write data width.
REQ-002 The block SHALL have parameter IDX_W, default 2, giving the register index width (4 registers).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port alu_req  input  1  ALU writeback request, held high until granted.
REQ-006 The block SHALL have ports alu_index  input  IDX_W and alu_data  input  DATA_W, the ALU target register and value, stable while alu_req is high.
REQ-007 The block SHALL have port alu_grant  output  1  the ALU request is accepted this cycle.
REQ-008 The block SHALL have ports mem_req  input  1, mem_index  input  IDX_W, mem_data  input  DATA_W, and mem_grant  output  1, with the same meaning for the load-return requester.
REQ-009 The block SHALL have port freeze  input  1  when high, no new grants are issued.
REQ-010 The block SHALL have ports write_enable  output  1, write_reg_index  output  IDX_W, and write_data  output  DATA_W, all registered, driving the register file write port.
REQ-011 The block SHALL have port pending_mask  output  2**IDX_W  one bit per register, set while a granted write to it is in the output stage.

Function
REQ-012 Grants SHALL be combinational from the req inputs, freeze, and the arbiter state; at most one grant SHALL be high per cycle.
REQ-013 On a grant in cycle N, the block SHALL capture index and data; in cycle N+1 it SHALL present write_enable=1 with those values; latency is 1 cycle; throughput is 1 write per cycle.
REQ-014 With no grant in cycle N, write_enable SHALL be 0 in cycle N+1; write_reg_index and write_data SHALL hold their last values.
REQ-015 The arbiter FSM SHALL have states IDLE, LAST_ALU, and LAST_MEM; reset SHALL enter IDLE.
REQ-016 In IDLE with both requesting, ALU SHALL win; in LAST_ALU, MEM SHALL win; in LAST_MEM, ALU SHALL win.
REQ-017 With a single requester, that requester SHALL be granted in any state.
REQ-018 After an ALU grant, the FSM SHALL go to LAST_ALU; after a MEM grant, to LAST_MEM; with no grant, it SHALL hold its state.
REQ-019 While freeze=1, both grants SHALL be 0 and the FSM SHALL hold; a write already in the output stage SHALL still complete.
REQ-020 When both requesters target the same index in the same cycle, only one SHALL be granted; the loser SHALL be granted the next cycle, so the last write wins in grant order.
REQ-021 pending_mask SHALL equal the one-hot decode of write_reg_index when write_enable=1, and 0 otherwise.

Reset
REQ-022 On reset low, the block SHALL immediately set write_enable=0, write_reg_index=0, write_data=0, and pending_mask=0, set the FSM to IDLE, and clear the counters.
REQ-023 A write captured before a mid-operation reset SHALL be discarded; grants SHALL be 0 while reset is low.
REQ-024 Normal operation SHALL resume on the first rising clk edge after reset deasserts.

Configuration
REQ-025 With macro REGFILE_ARB_STATS_EN defined, the block SHALL add three outputs: alu_grant_count (16 bits), mem_grant_count (16 bits), and conflict_count (16 bits).
REQ-026 conflict_count SHALL increment on each cycle with both requests high and freeze low.
REQ-027 All three counters SHALL wrap from 0xFFFF to 0x0000.
REQ-028 Without REGFILE_ARB_STATS_EN, these ports and counters SHALL not exist, and behaviour SHALL otherwise be identical.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, LAST_ALU, LAST_MEM) and the DATA_W and IDX_W defaults.
REQ-030 The block SHALL contain one sub-module, rr_arbiter2: combinational two-way round-robin grant logic from req pair and state.

Verification
REQ-031 The bench SHALL check: reset low then high; alu_req=1, idx=2, data=0x1234 -> alu_grant=1 cycle 0; write_enable=1, index=2, data=0x1234, pending_mask=0100 at cycle 1.
REQ-032 The bench SHALL check: both req held 4 cycles from IDLE -> grants ALU, MEM, ALU, MEM; write_enable high on 4 consecutive cycles.
REQ-033 The bench SHALL check: ALU idx=1 data=0xAAAA and MEM idx=1 data=0x5555 same cycle from IDLE -> outputs 0xAAAA then 0x5555 on index 1.
REQ-034 The bench SHALL check: freeze=1 for 3 cycles with both requesting -> no grants, FSM held; freeze=0 -> grant follows held state.
REQ-035 The bench SHALL check: reset asserted the cycle after a grant -> write_enable=0 immediately, no write issued, FSM in IDLE.
REQ-036 The bench SHALL check, with REGFILE_ARB_STATS_EN: preload conflict_count to 0xFFFF via 65535 conflicts, then one more conflict -> conflict_count=0x0000.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: arbiter state encoding
// and default widths. Optional statistics are enabled with REGFILE_ARB_STATS_EN.
package regfile_write_arbiter_pkg;
  localparam int DATA_W_DEFAULT = 16;
  localparam int IDX_W_DEFAULT  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAST_ALU = 2'd1,
    LAST_MEM = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic: the requester that did not win last goes
// first on a collision; a lone requester always wins. Purely combinational.
module rr_arbiter2 import regfile_write_arbiter_pkg::*; (
  input  logic       alu_req,
  input  logic       mem_req,
  input  logic       enable,
  input  arb_state_t state,
  output logic       alu_grant,
  output logic       mem_grant
);
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (enable) begin
      if (alu_req && mem_req) begin
        // IDLE and LAST_MEM both favour the ALU.
        if (state == LAST_ALU) mem_grant = 1'b1;
        else                   alu_grant = 1'b1;
      end else begin
        alu_grant = alu_req;
        mem_grant = mem_req;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load-return writebacks onto one register-file write port
// with a one-cycle registered output stage. Define REGFILE_ARB_STATS_EN to add
// grant and conflict counters.
//
// Handshake: a requester raises req with stable index/data and holds it until
// its grant is seen high in the same cycle; the write appears on the port in the
// following cycle. The freeze input suppresses new grants only.
module regfile_write_arbiter import regfile_write_arbiter_pkg::*; #(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IDX_W  = IDX_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_req,
  input  logic [IDX_W-1:0]        alu_index,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_grant,
  input  logic                    mem_req,
  input  logic [IDX_W-1:0]        mem_index,
  input  logic [DATA_W-1:0]       mem_data,
  output logic                    mem_grant,
  input  logic                    freeze,
  output logic                    write_enable,
  output logic [IDX_W-1:0]        write_reg_index,
  output logic [DATA_W-1:0]       write_data,
  output logic [(1<<IDX_W)-1:0]   pending_mask,
  output arb_state_t              arb_state
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]             alu_grant_count,
  output logic [15:0]             mem_grant_count,
  output logic [15:0]             conflict_count
`endif
);
  logic grant_enable;

  // Reset is folded in so no grant can be observed while the block is held in reset.
  assign grant_enable = reset & ~freeze;

  rr_arbiter2 u_arb (
    .alu_req   (alu_req),
    .mem_req   (mem_req),
    .enable    (grant_enable),
    .state     (arb_state),
    .alu_grant (alu_grant),
    .mem_grant (mem_grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_state       <= IDLE;
      write_enable    <= 1'b0;
      write_reg_index <= '0;
      write_data      <= '0;
    end else begin
      write_enable <= alu_grant | mem_grant;
      if (alu_grant) begin
        arb_state       <= LAST_ALU;
        write_reg_index <= alu_index;
        write_data      <= alu_data;
      end else if (mem_grant) begin
        arb_state       <= LAST_MEM;
        write_reg_index <= mem_index;
        write_data      <= mem_data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (write_enable) pending_mask[write_reg_index] = 1'b1;
  end

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_grant_count <= 16'd0;
      mem_grant_count <= 16'd0;
      conflict_count  <= 16'd0;
    end else begin
      if (alu_grant) alu_grant_count <= alu_grant_count + 16'd1;
      if (mem_grant) mem_grant_count <= mem_grant_count + 16'd1;
      if (alu_req && mem_req && !freeze) conflict_count <= conflict_count + 16'd1;
    end
  end
`endif
endmodule
